mips_instr_encoder: RTL
=======================

# mips_instr_encoder

Encoder counterpart to the pipeline control decoder. It accepts instruction fields (OpCode, Funct, register indices, shamt, immediate, jump target) over a valid/ready handshake and assembles 32-bit MIPS words in R/I/J format. Words are buffered in a small FIFO and written sequentially into instruction memory from a base address. The block serves as the program loader in front of the instruction memory during bring-up and test.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 32: instruction-memory byte-address width.
- BASE_ADDR, 0: first write address; word-aligned.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse that begins a load session.
- in_valid  in  1  field set present.
- in_ready  out  1  encoder accepts the field set this cycle.
- in_last  in  1  marks the final instruction of the session.
- OpCode  in  6  instruction opcode.
- Funct  in  6  function field, used for R-format only.
- rs, rt, rd  in  5 each  register indices.
- shamt  in  5  shift amount.
- imm  in  16  immediate.
- target  in  26  jump target field.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  byte address of the write.
- mem_wdata  out  32  encoded word.
- mem_busy  in  1  memory cannot take a write this cycle.
- done  out  1  session complete; held until the next start.
- err  out  1  sticky; an unsupported opcode was encoded as NOP.

## Operation
- Format selection:
  - R: OpCode 0x00 or 0x1c; word = {OpCode, rs, rt, rd, shamt, Funct}.
  - J: OpCode 0x02 or 0x03; word = {OpCode, target}.
  - I: OpCode 0x01, 0x04–0x0d, 0x0f, 0x23, 0x2b; word = {OpCode, rs, rt, imm}.
- Any other opcode is encoded as 0x00000000 (NOP) and sets err. err clears only on reset or start.
- States:
  - IDLE: in_ready=0, no writes. start → LOAD.
  - LOAD: accept and write instructions. The write of the in_last entry → DONE.
  - DONE: done=1, in_ready=0. start → LOAD.
- On start (from IDLE or DONE), the following are cleared: address counter to BASE_ADDR, FIFO, done, err, and the last-accepted flag.
- start while in LOAD is ignored.
- in_ready = (state==LOAD) && (count<DEPTH) && !last_accepted.
  - Once in_last has been accepted, no further input is taken in this session.
- Push happens when in_valid && in_ready. The encoded word and last flag are stored in the FIFO at the tail.
- mem_we = (state==LOAD) && (count!=0) && !mem_busy.
  - mem_wdata is the FIFO head; mem_addr is the address counter.
  - On a write: pop the head and add 4 to the address, wrapping modulo 2^ADDR_WIDTH.
- Push and pop in the same cycle leave count unchanged.
  - When full, in_ready is 0 even if a pop occurs that cycle.
- Reset values: state IDLE, FIFO empty (count 0), address counter BASE_ADDR, in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, done 0, err 0.

## Timing
- Latency: an instruction accepted in cycle N drives mem_we in cycle N+1 at the earliest, if the FIFO was empty and mem_busy=0.
- Throughput: one word per cycle in steady state.
- mem_we, mem_addr and mem_wdata are combinational from registered state and mem_busy.
- mem_busy=1 holds the head and address stable; nothing is lost.
- The cycle after the in_last word is written: state=DONE and done=1.
- start pulse in cycle N: state=LOAD in cycle N+1, so in_ready can first be 1 in N+1.
- Reset asserted mid-session: all outputs take their reset values asynchronously; buffered words are discarded.
- err is registered: it rises the cycle after the offending accept.

## Test plan
- Basic I-format: start, then addi (op 0x08, rs 0, rt 8, imm 5) with in_last=1.
  - Expect mem_we at BASE_ADDR with 0x20080005, then done=1 the next cycle.
- Mixed formats: add (rs 8, rt 9, rd 10, Funct 0x20), sll (rt 9, rd 8, shamt 2), j (target 0x0100000), lw (op 0x23, rs 29, rt 8, imm 4).
  - Expect words 0x01095020, 0x00094080, 0x08100000, 0x8FA80004 at addresses 0, 4, 8, 0xC.
- Backpressure: hold mem_busy=1 and present 6 instructions.
  - Expect in_ready to drop after 4 accepts, mem_we=0 throughout, no loss.
  - Release mem_busy: expect all 6 words written in order, one per cycle.
- Unsupported opcode 0x10: expect word 0x00000000 written and err=1 until the next start.
- Address wrap: ADDR_WIDTH=4, BASE_ADDR=0xC, 2 instructions.
  - Expect writes at 0xC then 0x0.
- Reset mid-session: assert reset with 3 words buffered.
  - Expect mem_we=0, in_ready=0, done=0 immediately, and no writes until the next start.

Source files
------------

// File: rtl/mips_instr_encoder_if.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder_if
// Bundles the two buses of the MIPS program loader:
//   - Field side: in_valid/in_ready/in_last handshake with the instruction
//     fields OpCode, Funct, rs, rt, rd, shamt, imm and target.
//   - Memory side: mem_we/mem_addr/mem_wdata write strobe with mem_busy stall.
// Modports:
//   master : the agent that supplies fields and models the instruction memory.
//   slave  : the encoder itself.
// -----------------------------------------------------------------------------
interface mips_instr_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // Field-side handshake and payload
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [5:0]            OpCode;
  logic [5:0]            Funct;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [25:0]           target;

  // Instruction-memory write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_busy;

  modport master (
    output in_valid, in_last, OpCode, Funct, rs, rt, rd, shamt, imm, target,
    output mem_busy,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, OpCode, Funct, rs, rt, rd, shamt, imm, target,
    input  mem_busy,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
// Program loader in front of the instruction memory. Accepts instruction
// fields over a valid/ready handshake, assembles R/I/J-format MIPS words,
// buffers them in a small FIFO and writes them to consecutive word addresses
// starting at BASE_ADDR.
// Ports:
//   clk    : single clock, rising edge.
//   reset  : asynchronous, active-high; clears all state.
//   start  : one-cycle pulse that opens a load session (ignored while loading).
//   bus    : field handshake + instruction-memory write port (slave side).
//   done   : session finished (in_last word written); held until next start.
//   err    : sticky; an unsupported opcode was encoded as NOP this session.
// -----------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int unsigned          DEPTH      = 4,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  mips_instr_encoder_if.slave        bus,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_acc_q;
  logic                  done_q;
  logic                  err_q;

  // FIFO storage: encoded word plus the in_last marker of each entry.
  logic [31:0]           word_mem [DEPTH];
  logic                  last_mem [DEPTH];

  logic                  in_ready;
  logic                  push;
  logic                  pop;
  logic [31:0]           enc_word;
  logic                  enc_bad;

  // ---------------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults ahead of the case keep every path assigned, so no latch.
    enc_word = '0;
    enc_bad  = 1'b0;
    case (bus.OpCode) inside
      6'h00, 6'h1c:
        enc_word = {bus.OpCode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.Funct};
      6'h02, 6'h03:
        enc_word = {bus.OpCode, bus.target};
      6'h01, [6'h04:6'h0d], 6'h0f, 6'h23, 6'h2b:
        enc_word = {bus.OpCode, bus.rs, bus.rt, bus.imm};
      default:
        enc_bad = 1'b1;  // unsupported: leave the NOP word, flag it
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake, FIFO occupancy and memory write port
  // ---------------------------------------------------------------------------
  // Full blocks input even when a pop happens this cycle, so in_ready never
  // depends on mem_busy.
  assign in_ready = (state_q == S_LOAD) && (count_q < CNT_W'(DEPTH)) && !last_acc_q;
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == S_LOAD) && (count_q != '0) && !bus.mem_busy;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = pop;
  assign bus.mem_addr  = addr_q;
  // Storage is not reset, so an empty FIFO presents zero rather than stale data.
  assign bus.mem_wdata = (count_q != '0) ? word_mem[head_q] : 32'h0;
  assign done          = done_q;
  assign err           = err_q;

  // NOTE: FIFO storage has no reset; occupancy is tracked by count_q and the
  // read side is gated, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[tail_q] <= enc_word;
      last_mem[tail_q] <= bus.in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM with pointers, address counter and status flags
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      last_acc_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            last_acc_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (push) begin
            tail_q <= tail_q + PTR_W'(1);
            if (bus.in_last) last_acc_q <= 1'b1;
            if (enc_bad)     err_q      <= 1'b1;
          end
          if (pop) begin
            head_q <= head_q + PTR_W'(1);
            addr_q <= addr_q + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
            if (last_mem[head_q]) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          count_q <= count_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
